// File: rtl/gray_count_arbiter_if.sv
// Request/grant bundle for gray_count_arbiter.
// master: the arbiter side; slave: the requester side.
interface gray_count_arbiter_if #(
  parameter int WIDTH = 3
) ();
  logic [3:0]       req;
  logic [3:0]       grant;
  logic             busy;
  logic [WIDTH-1:0] gray_out;
  logic             done;

  modport master (
    input  req,
    output grant,
    output busy,
    output gray_out,
    output done
  );

  modport slave (
    output req,
    input  grant,
    input  busy,
    input  gray_out,
    input  done
  );
endinterface

// File: rtl/gray_count_arbiter.sv
// Round-robin 4-way arbiter; the winner owns a Gray-coded run counter.
// Define GRAY_ARB_ABORT_EN to end a run early when the winner drops req.
module gray_count_arbiter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_count_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] gray_nx;
  logic [3:0]       grant;
  logic [3:0]       grant_nx;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nx;
  logic [1:0]       win;
  logic [1:0]       win_nx;
  logic             done_q;
  logic             done_nx;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;
  logic             abort;

  // First set request at or after ptr, wrapping mod 4.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef GRAY_ARB_ABORT_EN
  assign abort = !bus.req[win];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    count_nx = count;
    grant_nx = grant;
    ptr_nx   = ptr;
    win_nx   = win;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        count_nx = '0;
        grant_nx = '0;
        if (found) begin
          state_nx = RUN;
          win_nx   = pick;
          grant_nx = 4'b0001 << pick;
        end
      end
      RUN: begin
        if (count == LAST || abort) begin
          state_nx = DONE;
          grant_nx = '0;
          done_nx  = 1'b1;
          ptr_nx   = win + 2'd1;
        end else begin
          count_nx = count + WIDTH'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        count_nx = '0;
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
        grant_nx = '0;
      end
    endcase
    gray_nx = count_nx ^ (count_nx >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      gray   <= '0;
      grant  <= '0;
      ptr    <= '0;
      win    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      gray   <= gray_nx;
      grant  <= grant_nx;
      ptr    <= ptr_nx;
      win    <= win_nx;
      done_q <= done_nx;
    end
  end

  assign bus.grant    = grant;
  assign bus.busy     = |grant;
  assign bus.gray_out = gray;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_gray_count_arbiter.sv
// Scoreboard bench for gray_count_arbiter: default build plus
// a WIDTH=1/MAX_COUNT=1 instance.
module tb_gray_count_arbiter;

  typedef struct {
    logic [3:0] grant;
    logic       busy;
    logic [2:0] gray;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  string phase = "reset";

  exp_t sb0[$];
  exp_t sb1[$];

  logic [2:0] GRAY3 [7] = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101};

  gray_count_arbiter_if #(.WIDTH(3)) if0 ();
  gray_count_arbiter_if #(.WIDTH(1)) if1 ();

  gray_count_arbiter #(
    .WIDTH(3),
    .MAX_COUNT(6)
  ) dut0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(if0.master)
  );

  gray_count_arbiter #(
    .WIDTH(1),
    .MAX_COUNT(1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(if1.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert ($onehot0(if0.grant) && $onehot0(if1.grant)
            && if0.busy == (if0.grant != 0)
            && if1.busy == (if1.grant != 0))
      else $error("FAIL onehot grant0=%b grant1=%b", if0.grant, if1.grant);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp0(input logic [3:0] g, input logic b,
                      input logic [2:0] gy, input logic d);
    exp_t e;
    e.grant = g;
    e.busy  = b;
    e.gray  = gy;
    e.done  = d;
    sb0.push_back(e);
  endtask

  task automatic exp1(input logic [3:0] g, input logic b,
                      input logic gy, input logic d);
    exp_t e;
    e.grant = g;
    e.busy  = b;
    e.gray  = {2'b00, gy};
    e.done  = d;
    sb1.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      check({phase, ".grant"}, 32'(if0.grant), 32'(e.grant));
      check({phase, ".busy"}, 32'(if0.busy), 32'(e.busy));
      check({phase, ".gray"}, 32'(if0.gray_out), 32'(e.gray));
      check({phase, ".done"}, 32'(if0.done), 32'(e.done));
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check({phase, ".grant1"}, 32'(if1.grant), 32'(e.grant));
      check({phase, ".busy1"}, 32'(if1.busy), 32'(e.busy));
      check({phase, ".gray1"}, 32'(if1.gray_out), 32'(e.gray));
      check({phase, ".done1"}, 32'(if1.done), 32'(e.done));
    end
  endtask

  task automatic check_zero();
    check({phase, ".rgrant"}, 32'(if0.grant), 32'd0);
    check({phase, ".rbusy"}, 32'(if0.busy), 32'd0);
    check({phase, ".rgray"}, 32'(if0.gray_out), 32'd0);
    check({phase, ".rdone"}, 32'(if0.done), 32'd0);
  endtask

  // Called at a negedge; returns at a negedge with rst_n released.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full grant with r held: 7 RUN, DONE, IDLE.
  task automatic run_grant(input logic [3:0] r, input logic [3:0] g);
    if0.req = r;
    for (int c = 0; c < 7; c++) exp0(g, 1'b1, GRAY3[c], 1'b0);
    exp0(4'b0, 1'b0, GRAY3[6], 1'b1);
    exp0(4'b0, 1'b0, 3'b0, 1'b0);
    repeat (9) step();
  endtask

  initial begin
    if0.req = 4'b0;
    if1.req = 4'b0;
    #3;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;

    phase = "idle";
    repeat (2) exp0(4'b0, 1'b0, 3'b0, 1'b0);
    repeat (2) step();

    phase = "single";
    run_grant(4'b0001, 4'b0001);
    run_grant(4'b0001, 4'b0001);

    phase = "midchg";
    if0.req = 4'b0001;
    for (int c = 0; c < 7; c++) exp0(4'b0001, 1'b1, GRAY3[c], 1'b0);
    exp0(4'b0, 1'b0, GRAY3[6], 1'b1);
    exp0(4'b0, 1'b0, 3'b0, 1'b0);
    repeat (3) step();
    if0.req = 4'b1001;
    repeat (6) step();
    phase = "rotate";
    run_grant(4'b1001, 4'b1000);

    phase = "rr_all";
    do_reset();
    run_grant(4'b1111, 4'b0001);
    run_grant(4'b1111, 4'b0010);
    run_grant(4'b1111, 4'b0100);
    run_grant(4'b1111, 4'b1000);
    run_grant(4'b1111, 4'b0001);

    phase = "ptr2";
    run_grant(4'b0010, 4'b0010);
    run_grant(4'b0011, 4'b0001);
    run_grant(4'b0011, 4'b0010);

    phase = "midrst";
    if0.req = 4'b0100;
    for (int c = 0; c < 4; c++) exp0(4'b0100, 1'b1, GRAY3[c], 1'b0);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero();
    repeat (2) begin
      @(negedge clk);
      check("midrst.nodone", 32'(if0.done), 32'd0);
      check("midrst.nogrant", 32'(if0.grant), 32'd0);
    end
    rst_n = 1'b1;
    phase = "postrst";
    run_grant(4'b1111, 4'b0001);
    run_grant(4'b1000, 4'b1000);

    phase = "abort";
    if0.req = 4'b0001;
    for (int c = 0; c < 3; c++) exp0(4'b0001, 1'b1, GRAY3[c], 1'b0);
    repeat (3) step();
    if0.req = 4'b0000;
`ifdef GRAY_ARB_ABORT_EN
    exp0(4'b0, 1'b0, 3'b011, 1'b1);
    exp0(4'b0, 1'b0, 3'b0, 1'b0);
    repeat (2) step();
`else
    for (int c = 3; c < 7; c++) exp0(4'b0001, 1'b1, GRAY3[c], 1'b0);
    exp0(4'b0, 1'b0, GRAY3[6], 1'b1);
    exp0(4'b0, 1'b0, 3'b0, 1'b0);
    repeat (6) step();
`endif

    phase = "narrow";
    if1.req = 4'b0100;
    exp1(4'b0100, 1'b1, 1'b0, 1'b0);
    exp1(4'b0100, 1'b1, 1'b1, 1'b0);
    exp1(4'b0000, 1'b0, 1'b1, 1'b1);
    exp1(4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    if1.req = 4'b0000;

    check("sb0.left", 32'(sb0.size()), 32'd0);
    check("sb1.left", 32'(sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
